// File: rtl/ahb_arbiter.sv
// Three-master AHB bus arbiter: round-robin with bounded tenure, parked on master1.
// Optional locked tenures are enabled by defining AHB_ARB_LOCK_EN.
module ahb_arbiter #(
   parameter logic [1:0] MASTER1    = 2'b00,
   parameter logic [1:0] MASTER2    = 2'b01,
   parameter logic [1:0] MASTER3    = 2'b10,
   parameter int         MAX_TENURE = 16
) (
   input  logic       hclk,
   input  logic       hreset,
   input  logic [2:0] hbusreq,
   input  logic [2:0] hlock,
   input  logic       hready,
   output logic [2:0] hgrant,
   output logic [1:0] mux_sel,
   output logic [1:0] data_sel,
   output logic       hmastlock,
   output logic [1:0] arb_state
);

   typedef enum logic [1:0] {PARK = 2'd0, OWN = 2'd1, LOCK = 2'd2} state_t;

   localparam logic [7:0] MAX_T = 8'(MAX_TENURE);

   state_t     state, nxt_state;
   logic [1:0] last_owner, nxt_last;
   logic [7:0] tenure, nxt_tenure, tenure_inc;
   logic [2:0] lock_req, others, pick_all, pick_oth, arb_pick;
   logic [2:0] nxt_grant;
   logic [1:0] nxt_mux;
   logic       owner_req, owner_lock, do_arb;

`ifdef AHB_ARB_LOCK_EN
   assign lock_req = hlock;
`else
   assign lock_req = hlock & 3'b000;
`endif

   // Returns {found, index}; search starts at the master after 'last' (0->1->2->0).
   function automatic logic [2:0] rr_pick(input logic [2:0] req, input logic [1:0] last);
      logic [1:0] cand;
      logic [2:0] res;
      cand = last;
      res  = 3'b000;
      for (int i = 0; i < 3; i++) begin
         cand = (cand == 2'd2) ? 2'd0 : cand + 2'd1;
         if (req[cand] && !res[2]) res = {1'b1, cand};
      end
      return res;
   endfunction

   function automatic logic [1:0] enc(input logic [1:0] idx);
      case (idx)
         2'd0:    return MASTER1;
         2'd1:    return MASTER2;
         default: return MASTER3;
      endcase
   endfunction

   always_comb begin
      others     = hbusreq & ~(3'b001 << last_owner);
      pick_all   = rr_pick(hbusreq, last_owner);
      pick_oth   = rr_pick(others, last_owner);
      owner_req  = hbusreq[last_owner];
      owner_lock = lock_req[last_owner];
      tenure_inc = (tenure >= MAX_T) ? MAX_T : tenure + 8'd1;

      nxt_state  = state;
      nxt_last   = last_owner;
      nxt_tenure = tenure;
      do_arb     = 1'b0;
      arb_pick   = pick_all;

      case (state)
         PARK: do_arb = 1'b1;
         OWN: begin
            if (!owner_req) begin
               do_arb = 1'b1;
            end else if (tenure_inc == MAX_T && others != 3'b000) begin
               do_arb   = 1'b1;
               arb_pick = pick_oth;
            end else begin
               nxt_tenure = tenure_inc;
            end
         end
         LOCK: begin
            // Tenure counter stays frozen while locked.
            if (!owner_req) do_arb = 1'b1;
            else if (!owner_lock) nxt_state = OWN;
         end
         default: do_arb = 1'b1;
      endcase

      if (do_arb) begin
         nxt_tenure = 8'd0;
         if (arb_pick[2]) begin
            nxt_last  = arb_pick[1:0];
            nxt_state = lock_req[arb_pick[1:0]] ? LOCK : OWN;
         end else begin
            nxt_state = PARK;
         end
      end

      nxt_grant = (nxt_state == PARK) ? 3'b001 : (3'b001 << nxt_last);
      nxt_mux   = (nxt_state == PARK) ? MASTER1 : enc(nxt_last);
   end

   always_ff @(posedge hclk) begin
      if (hreset) begin
         state      <= PARK;
         last_owner <= 2'd2;
         tenure     <= 8'd0;
         hgrant     <= 3'b001;
         mux_sel    <= MASTER1;
         data_sel   <= MASTER1;
         hmastlock  <= 1'b0;
      end else if (hready) begin
         state      <= nxt_state;
         last_owner <= nxt_last;
         tenure     <= nxt_tenure;
         hgrant     <= nxt_grant;
         mux_sel    <= nxt_mux;
         data_sel   <= mux_sel;
         hmastlock  <= (nxt_state == LOCK);
      end
   end

   assign arb_state = state;

endmodule

// File: tb/tb_ahb_arbiter.sv
// Scoreboard bench for ahb_arbiter: a behavioural model pushes expected outputs per
// driven cycle, which are popped and compared one cycle later.
module tb_ahb_arbiter;

   localparam int MAX_T = 4;
`ifdef AHB_ARB_LOCK_EN
   localparam bit LOCK_EN = 1'b1;
`else
   localparam bit LOCK_EN = 1'b0;
`endif

   logic       hclk = 1'b0;
   logic       hreset, hready, hmastlock;
   logic [2:0] hbusreq, hlock, hgrant;
   logic [1:0] mux_sel, data_sel, arb_state;

   ahb_arbiter #(.MAX_TENURE(MAX_T)) dut (
      .hclk(hclk), .hreset(hreset), .hbusreq(hbusreq), .hlock(hlock), .hready(hready),
      .hgrant(hgrant), .mux_sel(mux_sel), .data_sel(data_sel), .hmastlock(hmastlock),
      .arb_state(arb_state)
   );

   always #5 hclk = ~hclk;

   int n_checks = 0;
   int n_errors = 0;
   logic [9:0] exp_q[$];

   // Model: owner 0 = parked, 1..3 = master number; data is master number of data phase.
   int m_owner, m_last, m_cnt, m_data;
   bit m_locked;

   task automatic check_eq(input string tag, input logic [9:0] got, input logic [9:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got {grant,mux,data,lock,state}=%b expected=%b", tag, got, exp);
      end
   endtask

   function automatic int pick(input logic [2:0] req, input int last, input int excl);
      for (int k = 1; k <= 3; k++) begin
         int m;
         m = ((last - 1 + k) % 3) + 1;
         if (req[m-1] && m != excl) return m;
      end
      return 0;
   endfunction

   task automatic m_arb(input int w, input logic [2:0] lk);
      m_cnt = 0;
      if (w == 0) begin
         m_owner  = 0;
         m_locked = 0;
      end else begin
         m_owner  = w;
         m_last   = w;
         m_locked = lk[w-1];
      end
   endtask

   task automatic model_step(input logic rst, input logic rdy, input logic [2:0] req,
                             input logic [2:0] lk_in);
      logic [2:0] lk;
      int c;
      lk = LOCK_EN ? lk_in : 3'b000;
      if (rst) begin
         m_owner = 0; m_last = 3; m_cnt = 0; m_locked = 0; m_data = 1;
      end else if (rdy) begin
         m_data = (m_owner == 0) ? 1 : m_owner;
         if (m_owner == 0) begin
            m_arb(pick(req, m_last, 0), lk);
         end else if (m_locked) begin
            if (!req[m_owner-1]) m_arb(pick(req, m_last, 0), lk);
            else if (!lk[m_owner-1]) m_locked = 0;
         end else if (!req[m_owner-1]) begin
            m_arb(pick(req, m_last, 0), lk);
         end else begin
            c = (m_cnt + 1 > MAX_T) ? MAX_T : m_cnt + 1;
            if (c == MAX_T && pick(req, m_last, m_owner) != 0) m_arb(pick(req, m_last, m_owner), lk);
            else m_cnt = c;
         end
      end
   endtask

   function automatic logic [9:0] model_out();
      logic [2:0] g;
      logic [1:0] mx, dt, st;
      int who;
      who = (m_owner == 0) ? 1 : m_owner;
      g   = 3'b001 << (who - 1);
      mx  = 2'(who - 1);
      dt  = 2'(m_data - 1);
      st  = (m_owner == 0) ? 2'd0 : (m_locked ? 2'd2 : 2'd1);
      return {g, mx, dt, m_locked, st};
   endfunction

   task automatic drive(input logic rst, input logic rdy, input logic [2:0] req,
                        input logic [2:0] lk, input string tag);
      hreset = rst; hready = rdy; hbusreq = req; hlock = lk;
      model_step(rst, rdy, req, lk);
      exp_q.push_back(model_out());
      @(posedge hclk);
      #1;
      check_eq(tag, {hgrant, mux_sel, data_sel, hmastlock, arb_state}, exp_q.pop_front());
   endtask

   initial begin
      hreset = 1'b1; hready = 1'b1; hbusreq = 3'b000; hlock = 3'b000;

      repeat (2) drive(1'b1, 1'b0, 3'b000, 3'b000, "reset");
      repeat (10) drive(1'b0, 1'b1, 3'b000, 3'b000, "park_idle");
      repeat (16) drive(1'b0, 1'b1, 3'b111, 3'b000, "rotate_all");

      // Master2 owns, then a long wait state while master3 joins.
      repeat (3) drive(1'b0, 1'b1, 3'b010, 3'b000, "m2_own");
      repeat (5) drive(1'b0, 1'b0, 3'b110, 3'b000, "hready_hold");
      repeat (8) drive(1'b0, 1'b1, 3'b110, 3'b000, "hready_resume");

      // Master3 locked tenure while everyone requests, then release.
      drive(1'b1, 1'b1, 3'b000, 3'b000, "reset_lock");
      repeat (2) drive(1'b0, 1'b1, 3'b100, 3'b100, "m3_lock_grant");
      repeat (20) drive(1'b0, 1'b1, 3'b111, 3'b100, "m3_lock_hold");
      repeat (8) drive(1'b0, 1'b1, 3'b111, 3'b000, "m3_unlock");

      // Reset in the middle of a master2 locked tenure.
      drive(1'b1, 1'b1, 3'b000, 3'b000, "reset_m2");
      repeat (4) drive(1'b0, 1'b1, 3'b010, 3'b010, "m2_lock");
      drive(1'b1, 1'b0, 3'b010, 3'b010, "reset_mid_lock");
      repeat (3) drive(1'b0, 1'b1, 3'b110, 3'b000, "post_reset_arb");

      // Constrained-random traffic with wait states and rare resets.
      for (int i = 0; i < 300; i++) begin
         drive(($urandom_range(0, 99) < 2), ($urandom_range(0, 99) < 80),
               3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), "random");
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

// File: doc/ahb_arbiter.md
AHB_ARBITER -- requirements
Module: ahb_arbiter

Interface
REQ-001 Parameter MASTER1, default 2'b00: mux_sel encoding for master 1.
REQ-002 Parameter MASTER2, default 2'b01: mux_sel encoding for master 2.
REQ-003 Parameter MASTER3, default 2'b10: mux_sel encoding for master 3.
REQ-004 Parameter MAX_TENURE, default 16: maximum owned hready-cycles (1..255) before forced handover when another master requests.
REQ-005 hclk  input  1  sole clock; all state updates on the rising edge.
REQ-006 hreset  input  1  synchronous, active-high reset.
REQ-007 hbusreq  input  3  bus request; bit0=master1, bit1=master2, bit2=master3.
REQ-008 hlock  input  3  locked-transfer request, same bit mapping as hbusreq.
REQ-009 hready  input  1  slave ready; qualifies every arbitration and phase update.
REQ-010 hgrant  output  3  one-hot grant, same bit mapping as hbusreq.
REQ-011 mux_sel  output  2  address-phase owner (MASTERn encoding); drives the address/hwrite mux select.
REQ-012 data_sel  output  2  data-phase owner (MASTERn encoding); drives the write-data mux select.
REQ-013 hmastlock  output  1  current address-phase owner holds a locked tenure.

Function
REQ-014 Outputs shall be registered; hgrant and mux_sel always encode the same master.
REQ-015 State, grant, counter and pointer updates shall occur only on edges where hready=1; with hready=0 all registers hold.
REQ-016 FSM states: PARK (no request, master1 parked), OWN (granted master requesting), LOCK (granted master locked).
REQ-017 PARK: if any hbusreq set, grant the winner of the round-robin -> OWN (or LOCK if the winner's hlock=1); else stay PARK with master1 granted.
REQ-018 Round-robin order starts at the master after last_owner (1->2->3->1); first set hbusreq bit in that order wins.
REQ-019 OWN: owner hbusreq=0 -> rearbitrate same edge (-> OWN/LOCK on winner, PARK if none).
REQ-020 OWN: tenure counter increments per owned hready-cycle, saturating at MAX_TENURE; at MAX_TENURE with another request pending -> rearbitrate excluding the owner; with none pending -> stay, counter held.
REQ-021 Any grant change shall load last_owner with the new owner and clear the tenure counter.
REQ-022 LOCK: owner is never preempted; tenure counter frozen; exit to OWN when owner hlock=0 with hbusreq=1, else rearbitrate as REQ-019.
REQ-023 hmastlock shall be 1 exactly while in LOCK.
REQ-024 data_sel shall load the value of mux_sel on each hready=1 edge (one-transfer pipeline lag); holds when hready=0.
REQ-025 Simultaneous requests from all three masters shall be served in strict rotation, each holding at most MAX_TENURE cycles unlocked.
REQ-026 Unused mux_sel encoding (2'b11) shall never be produced.

Reset
REQ-027 On hreset=1 at a clock edge, regardless of hready: state=PARK, hgrant=3'b001, mux_sel=MASTER1, data_sel=MASTER1, hmastlock=0, tenure counter=0, last_owner=master3.
REQ-028 Reset mid-tenure (including LOCK) shall abandon the tenure; first post-reset arbitration treats master1 as highest priority.

Configuration
REQ-029 Macro AHB_ARB_LOCK_EN: when defined, hlock and LOCK state behave per REQ-016..REQ-023.
REQ-030 Without AHB_ARB_LOCK_EN: hlock ignored, LOCK state unreachable, hmastlock tied 0, all owners subject to MAX_TENURE.

Verification
REQ-031 Reset then hbusreq=3'b000 for 10 cycles -> hgrant=3'b001, mux_sel=2'b00, state PARK throughout.
REQ-032 hbusreq=3'b111 continuous, hready=1, MAX_TENURE=4 -> grant rotates master1,2,3,1 every 4 cycles; data_sel trails mux_sel by one cycle.
REQ-033 Master2 owns, hready=0 for 5 cycles while master3 requests -> hgrant, mux_sel, data_sel, counter unchanged until hready returns.
REQ-034 With AHB_ARB_LOCK_EN, master3 hlock=1 and hbusreq=1 for 20 cycles, others requesting -> master3 kept, hmastlock=1; drop hlock -> handover after MAX_TENURE.
REQ-035 hreset pulsed during master2 locked tenure -> next edge hgrant=3'b001, hmastlock=0; then hbusreq=3'b110 -> master2 granted next.
